smu_uart_mmio: RTL and testbench

SMU_UART_MMIO -- requirements
Module: smu_uart_mmio

---
 rtl/smu_uart_mmio.sv | 192 +++++++++++++++++++
 tb/tb_smu_uart_mmio.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/smu_uart_mmio.sv
// Memory-mapped UART: TX FIFO feeding a serialiser, and a two-flop-synchronised
// receiver with a single holding register and sticky overrun/framing flags.
`timescale 1ns/1ps
module smu_uart_mmio #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cs_n,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);
  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(TX_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  logic wr_tx, rd_rx, wr_clr;
  assign wr_tx  = !cs_n && we && (addr[3:2] == 2'd0) && byte_en[0];
  assign rd_rx  = !cs_n && re && (addr[3:2] == 2'd1);
  assign wr_clr = !cs_n && we && (addr[3:2] == 2'd3) && byte_en[0];

  logic unused_bus;
  assign unused_bus = ^{wdata[31:8], byte_en[3:1], addr[1:0]};

  // TX FIFO with one extra pointer bit to tell full from empty
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, fill;
  logic        tx_empty, tx_full, tx_pop, push_ok;

  assign fill     = wr_ptr - rd_ptr;
  assign tx_empty = (fill == '0);
  assign tx_full  = (fill == DEPTH_V);
  assign push_ok  = wr_tx && (!tx_full || tx_pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= wdata[7:0];
  end

  uart_state_t tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_bit_end, tx_busy;

  assign tx_bit_end = (tx_cnt == BIT_END);
  assign tx_busy    = (tx_state != ST_IDLE);

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      ST_IDLE:  if (!tx_empty) begin tx_next = ST_START; tx_pop = 1'b1; end
      ST_START: if (tx_bit_end) tx_next = ST_DATA;
      ST_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = ST_STOP;
      ST_STOP:  if (tx_bit_end) begin
                  if (!tx_empty) begin tx_next = ST_START; tx_pop = 1'b1; end
                  else tx_next = ST_IDLE;
                end
      default:  tx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_state == ST_IDLE || tx_bit_end) ? '0 : tx_cnt + 1'b1;
      if (tx_state == ST_START) tx_bit <= '0;
      else if (tx_state == ST_DATA && tx_bit_end) tx_bit <= tx_bit + 1'b1;
      if (tx_pop) tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
      else if (tx_state == ST_DATA && tx_bit_end) tx_shift <= {1'b0, tx_shift[7:1]};
    end
  end

  always_comb begin
    case (tx_state)
      ST_START: uart_txd = 1'b0;
      ST_DATA:  uart_txd = tx_shift[0];
      default:  uart_txd = 1'b1;
    endcase
  end

  // RX: START waits half a bit so every later tick lands mid-bit
  logic rxd_s1, rxd_s2, rxd_prev;
  uart_state_t rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_data;
  logic          rx_tick, rx_load, rx_bad;
  logic          rx_valid, rx_overrun, rx_frame_err;

  assign rx_tick = (rx_state == ST_START) ? (rx_cnt == HALF_END) : (rx_cnt == BIT_END);

  always_comb begin
    rx_next = rx_state;
    rx_load = 1'b0;
    rx_bad  = 1'b0;
    case (rx_state)
      ST_IDLE:  if (rxd_prev && !rxd_s2) rx_next = ST_START;
      ST_START: if (rx_tick) rx_next = rxd_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = ST_STOP;
      ST_STOP:  if (rx_tick) begin
                  rx_next = ST_IDLE;
                  rx_load = rxd_s2;
                  rx_bad  = !rxd_s2;
                end
      default:  rx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      rx_state <= rx_next;
      rx_cnt   <= (rx_state == ST_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_state == ST_START) rx_bit <= '0;
      else if (rx_state == ST_DATA && rx_tick) begin
        rx_bit   <= rx_bit + 1'b1;
        rx_shift <= {rxd_s2, rx_shift[7:1]};
      end
    end
  end

  // A byte landing in the same cycle as the RXDATA read is not an overrun
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_load) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      if (rx_load && rx_valid && !rd_rx) rx_overrun <= 1'b1;
      else if (wr_clr && wdata[4])       rx_overrun <= 1'b0;
      if (rx_bad)                        rx_frame_err <= 1'b1;
      else if (wr_clr && wdata[5])       rx_frame_err <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (!cs_n) begin
      case (addr[3:2])
        2'd1:    rdata = {23'd0, rx_valid, rx_data};
        2'd2:    rdata = {26'd0, rx_frame_err, rx_overrun, rx_valid, tx_busy, tx_full, tx_empty};
        default: rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_smu_uart_mmio.sv
// Bench for smu_uart_mmio: a default-rate instance for serial timing and RX,
// and a fast-divisor instance for FIFO depth and back-to-back frames.
`timescale 1ns/1ps
module tb_smu_uart_mmio;
  localparam int DIV_D = 125_000_000 / 115_200;
  localparam int DIV_F = 1_600_000 / 100_000;

  logic clk = 1'b0, n_rst = 1'b0;
  logic cs_n = 1'b1, cs_n_f = 1'b1, we = 1'b0, re = 1'b0;
  logic [3:0] addr = '0, byte_en = '0;
  logic [31:0] wdata = '0, rdata, rdata_f;
  logic txd, txd_f, rxd = 1'b1;

  int tests = 0, fails = 0, cyc = 0;
  int frames_d = 0, frames_f = 0, contig_d = 0, contig_f = 0;
  logic [7:0] tx_q[$], tx_q_f[$], rx_q[$];

  typedef struct {
    bit          fast;
    logic        csn;
    logic [3:0]  a;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[7];

  smu_uart_mmio dut (
    .clk(clk), .n_rst(n_rst), .cs_n(cs_n), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .uart_txd(txd), .uart_rxd(rxd)
  );

  smu_uart_mmio #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .TX_DEPTH(8)) dut_f (
    .clk(clk), .n_rst(n_rst), .cs_n(cs_n_f), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .byte_en(byte_en), .rdata(rdata_f), .uart_txd(txd_f), .uart_rxd(1'b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic busIdle();
    cs_n = 1'b1; cs_n_f = 1'b1; we = 1'b0; re = 1'b0;
  endtask

  task automatic busWrite(input bit fast, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    if (fast) cs_n_f = 1'b0; else cs_n = 1'b0;
    we = 1'b1; re = 1'b0; addr = a; wdata = d; byte_en = be;
    @(negedge clk);
  endtask

  task automatic busRead(input bit fast, input logic csn, input logic [3:0] a,
                         output logic [31:0] d);
    if (fast) cs_n_f = csn; else cs_n = csn;
    we = 1'b0; re = 1'b1; addr = a;
    #1 d = fast ? rdata_f : rdata;
    @(negedge clk);
    busIdle();
  endtask

  task automatic checkStatus(input bit fast, input string name, input logic [31:0] exp);
    logic [31:0] d;
    busRead(fast, 1'b0, 4'h8, d);
    check(name, d, exp);
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stop);
    if (stop) rx_q.push_back(b);
    rxd = 1'b0;
    repeat (DIV_D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV_D) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV_D) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Only the most recent byte survives an overrun
  task automatic readRx(input string name);
    logic [31:0] d, exp;
    while (rx_q.size() > 1) void'(rx_q.pop_front());
    exp = (rx_q.size() == 0) ? 32'h0 : {23'd0, 1'b1, rx_q.pop_front()};
    busRead(1'b0, 1'b0, 4'h4, d);
    check(name, d, exp);
  endtask

  // Checks every cycle of each frame against the queued byte; reset aborts quietly
  task automatic monitorTx(input bit fast);
    int div, start_cyc, prev_start, errs, b;
    logic [7:0] expb, got;
    logic line, expbit;
    bit have, aborted;
    div = fast ? DIV_F : DIV_D;
    prev_start = -1000000;
    forever begin
      @(negedge clk);
      line = fast ? txd_f : txd;
      if (n_rst && line == 1'b0) begin
        start_cyc = cyc; errs = 0; got = '0; aborted = 0; expb = '0;
        have = fast ? (tx_q_f.size() > 0) : (tx_q.size() > 0);
        if (have) expb = fast ? tx_q_f.pop_front() : tx_q.pop_front();
        else check(fast ? "tx_unexpected_f" : "tx_unexpected", 32'd1, 32'd0);
        for (int i = 0; i < 10 * div; i++) begin
          if (i > 0) @(negedge clk);
          if (!n_rst) begin aborted = 1; break; end
          line = fast ? txd_f : txd;
          b = i / div;
          expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : expb[b-1];
          if (line !== expbit) errs++;
          if (b >= 1 && b <= 8 && (i % div) == div / 2) got[b-1] = line;
        end
        if (!aborted && have) begin
          check(fast ? "tx_byte_f" : "tx_byte", {24'd0, got}, {24'd0, expb});
          check(fast ? "tx_timing_f" : "tx_timing", errs, 0);
          if (fast) frames_f++; else frames_d++;
          if (start_cyc - prev_start == 10 * div) begin
            if (fast) contig_f++; else contig_d++;
          end
        end
        prev_start = start_cyc;
      end
    end
  endtask

  initial monitorTx(1'b0);
  initial monitorTx(1'b1);

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d;
    int busy_errs, low_cnt;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 4'h4, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 4'h8, 32'h1};
    vecs[3] = '{1'b0, 1'b0, 4'hC, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 4'h8, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4'h8, 32'h1};
    vecs[6] = '{1'b0, 1'b0, 4'h9, 32'h1};

    repeat (3) @(negedge clk);
    check("rst_txd_held", {31'd0, txd}, 32'd1);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      busRead(vecs[i].fast, vecs[i].csn, vecs[i].a, d);
      check($sformatf("reset_vec%0d", i), d, vecs[i].exp);
    end

    // 0x55 frame with STATUS held on the bus to watch tx_busy
    tx_q.push_back(8'h55);
    busWrite(1'b0, 4'h0, 32'h55, 4'h1);
    cs_n = 1'b0; we = 1'b0; re = 1'b0; addr = 4'h8;
    @(negedge clk);
    busy_errs = 0;
    for (int i = 0; i < 10 * DIV_D; i++) begin
      if (rdata[2] !== 1'b1) busy_errs++;
      @(negedge clk);
    end
    busIdle();
    check("tx_busy_frame", busy_errs, 0);
    checkStatus(1'b0, "tx_done_status", 32'h1);
    check("tx_frames_d", frames_d, 1);
    check("tx_q_drained", tx_q.size(), 0);

    sendRx(8'hA3, 1'b1);
    checkStatus(1'b0, "rx_valid_set", 32'h9);
    readRx("rxdata_a3");
    checkStatus(1'b0, "rx_valid_clr", 32'h1);

    sendRx(8'h3C, 1'b0);
    checkStatus(1'b0, "frame_err_set", 32'h21);
    busWrite(1'b0, 4'hC, 32'h20, 4'h1);
    busIdle();
    checkStatus(1'b0, "frame_err_clr", 32'h1);

    rxd = 1'b0;
    repeat (300) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV_D) @(negedge clk);
    checkStatus(1'b0, "glitch_ignored", 32'h1);

    sendRx(8'h11, 1'b1);
    sendRx(8'hEE, 1'b1);
    checkStatus(1'b0, "overrun_set", 32'h19);
    readRx("rxdata_2nd");
    busWrite(1'b0, 4'hC, 32'h10, 4'h1);
    busIdle();
    checkStatus(1'b0, "overrun_clr", 32'h1);

    // Fast instance: byte_en gating, then nine writes into an eight-deep FIFO
    busWrite(1'b1, 4'h0, 32'h77, 4'b1110);
    busIdle();
    repeat (2) @(negedge clk);
    checkStatus(1'b1, "be0_gate", 32'h1);
    for (int i = 0; i < 9; i++) begin
      tx_q_f.push_back(8'(8'h30 + i));
      busWrite(1'b1, 4'h0, 32'(8'h30 + i), 4'hF);
    end
    busIdle();
    checkStatus(1'b1, "fifo_full", 32'h6);
    busWrite(1'b1, 4'h0, 32'hEE, 4'h1);
    busIdle();
    repeat (2000) @(negedge clk);
    check("fifo_frames", frames_f, 9);
    check("fifo_contig", contig_f, 8);
    check("fifo_q_drained", tx_q_f.size(), 0);
    checkStatus(1'b1, "fifo_idle", 32'h1);

    // Reset in the middle of a default-rate frame
    tx_q.push_back(8'h81);
    busWrite(1'b0, 4'h0, 32'h81, 4'h1);
    busIdle();
    repeat (3000) @(negedge clk);
    check("pre_rst_txd", {31'd0, txd}, 32'd0);
    #2 n_rst = 1'b0;
    #1 check("rst_txd_now", {31'd0, txd}, 32'd1);
    @(negedge clk);
    n_rst = 1'b1;
    tx_q.delete();
    @(negedge clk);
    checkStatus(1'b0, "post_rst_status", 32'h1);
    low_cnt = 0;
    for (int i = 0; i < 3 * DIV_D; i++) begin
      if (txd !== 1'b1) low_cnt++;
      @(negedge clk);
    end
    check("post_rst_line_idle", low_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
